// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register transaction controller.
//   spi_ctrl_state_t : transaction FSM states
//   CMD_RW_BIT/ADDR_W: command byte layout (bit 7 = read, bits 6:0 = address)
//   STATUS_*         : status byte layout {signature, 2'b00, overrun, timeout}
package spi_ctrl_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned ADDR_W         = 7;
  localparam int unsigned FRAME_W        = 16;
  localparam int unsigned CMD_RW_BIT     = 7;
  localparam int unsigned STATUS_TO_BIT  = 0;
  localparam int unsigned STATUS_OVR_BIT = 1;
  localparam int unsigned STATUS_SIG_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_WAIT,
    ST_RD_READY
  } spi_ctrl_state_t;

  // Assemble the status byte reported at the start of every frame.
  function automatic logic [DATA_W-1:0] status_byte(input logic [3:0] sig,
                                                    input logic       ovr,
                                                    input logic       to);
    logic [DATA_W-1:0] s;
    s = '0;
    s[STATUS_SIG_LSB +: 4] = sig;
    s[STATUS_OVR_BIT]      = ovr;
    s[STATUS_TO_BIT]       = to;
    return s;
  endfunction

endpackage

// File: rtl/spi_rd_timer.sv
// Read-response watchdog: loadable down-counter that flags expiry.
//   i_start    : load RD_TIMEOUT (the cycle after i_start counts as 1)
//   i_abort    : stop counting without expiring
//   o_expire_c : high during the RD_TIMEOUT-th cycle after the load
module spi_rd_timer #(
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_abort,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Zero means idle; start has priority over abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(RD_TIMEOUT);
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/spi_reg_ctrl.sv
// Byte-level SPI frame decoder driving the register bus.
//   clk, rst_n                : system clock, async active-low reset
//   cs_active, rx_valid/byte  : frame level and received bytes from the front-end
//   tx_byte                   : next byte to shift out (status or read data)
//   reg_addr/wr_en/wdata      : register write port
//   reg_rd_en/rdata/rd_valid  : register read port
//   err_timeout, err_overrun  : sticky errors, cleared by the next command byte
//   frame_cnt, busy           : completed non-empty frames, FSM not idle
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 16,
  parameter logic [7:0]  FILL_BYTE  = 8'hEE,
  parameter logic [3:0]  STATUS_SIG = 4'hA
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cs_active,
  input  logic               rx_valid,
  input  logic [DATA_W-1:0]  rx_byte,
  output logic [DATA_W-1:0]  tx_byte,
  output logic [ADDR_W-1:0]  reg_addr,
  output logic               reg_wr_en,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic               reg_rd_en,
  input  logic [DATA_W-1:0]  reg_rdata,
  input  logic               reg_rd_valid,
  output logic               err_timeout,
  output logic               err_overrun,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy
);

  spi_ctrl_state_t    r_state, w_state_nxt;
  logic               r_cs_d;
  logic [DATA_W-1:0]  r_tx, w_tx_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_wr_en, w_wr_en_nxt;
  logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
  logic               r_rd_en, w_rd_en_nxt;
  logic               r_err_to, w_err_to_nxt;
  logic               r_err_ovr, w_err_ovr_nxt;
  logic [FRAME_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic               r_had_byte, w_had_byte_nxt;
  logic               r_busy;
  logic               w_cs_rise, w_frame_end, w_abort, w_expire_c;

  spi_rd_timer #(.RD_TIMEOUT(RD_TIMEOUT)) u_rd_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_rd_en_nxt),
    .i_abort   (w_abort),
    .o_expire_c(w_expire_c)
  );

  // State and datapath registers. r_cs_d resets high so a frame already
  // active when reset releases is not mistaken for a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cs_d      <= 1'b1;
      r_tx        <= '0;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wdata     <= '0;
      r_rd_en     <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_ovr   <= 1'b0;
      r_frame_cnt <= '0;
      r_had_byte  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cs_d      <= cs_active;
      r_tx        <= w_tx_nxt;
      r_addr      <= w_addr_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_err_to    <= w_err_to_nxt;
      r_err_ovr   <= w_err_ovr_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_had_byte  <= w_had_byte_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    w_cs_rise       = cs_active & ~r_cs_d;
    w_frame_end     = (r_state != ST_IDLE) & ~cs_active;
    w_state_nxt     = r_state;
    w_tx_nxt        = r_tx;
    // Address advances in the cycle after each write strobe.
    w_addr_nxt      = r_wr_en ? r_addr + ADDR_W'(1) : r_addr;
    w_wr_en_nxt     = 1'b0;
    w_wdata_nxt     = r_wdata;
    w_rd_en_nxt     = 1'b0;
    w_err_to_nxt    = r_err_to;
    w_err_ovr_nxt   = r_err_ovr;
    w_frame_cnt_nxt = r_frame_cnt;
    w_had_byte_nxt  = r_had_byte | (rx_valid & (r_state != ST_IDLE));
    w_abort         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cs_rise) begin
          w_state_nxt    = ST_CMD;
          w_tx_nxt       = status_byte(STATUS_SIG, r_err_ovr, r_err_to);
          w_had_byte_nxt = 1'b0;
        end
      end
      ST_CMD: begin
        if (rx_valid) begin
          w_err_to_nxt  = 1'b0;
          w_err_ovr_nxt = 1'b0;
          w_addr_nxt    = rx_byte[ADDR_W-1:0];
          if (rx_byte[CMD_RW_BIT]) begin
            // A read whose frame is already closing is never requested.
            w_rd_en_nxt = cs_active;
            w_state_nxt = ST_RD_WAIT;
          end else begin
            w_state_nxt = ST_WR_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (rx_valid) begin
          w_wr_en_nxt = 1'b1;
          w_wdata_nxt = rx_byte;
        end
      end
      ST_RD_WAIT: begin
        if (rx_valid) begin
          w_err_ovr_nxt = 1'b1;
        end
        // Returning data beats an expiry in the same cycle.
        if (cs_active && reg_rd_valid) begin
          w_tx_nxt    = reg_rdata;
          w_state_nxt = ST_RD_READY;
          w_abort     = 1'b1;
        end else if (cs_active && w_expire_c) begin
          w_tx_nxt     = FILL_BYTE;
          w_err_to_nxt = 1'b1;
          w_state_nxt  = ST_RD_READY;
        end
      end
      ST_RD_READY: begin
        if (rx_valid && cs_active) begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_rd_en_nxt = 1'b1;
          w_state_nxt = ST_RD_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Frame close overrides the state move; any pending read is dropped.
    if (w_frame_end) begin
      w_state_nxt    = ST_IDLE;
      w_abort        = 1'b1;
      w_had_byte_nxt = 1'b0;
      if (r_had_byte || rx_valid) begin
        w_frame_cnt_nxt = r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  assign tx_byte     = r_tx;
  assign reg_addr    = r_addr;
  assign reg_wr_en   = r_wr_en;
  assign reg_wdata   = r_wdata;
  assign reg_rd_en   = r_rd_en;
  assign err_timeout = r_err_to;
  assign err_overrun = r_err_ovr;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = r_busy;

endmodule
